// File: rtl/cu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cu_pkg
// Desc     : Opcodes, ALU/bus select codes, state encoding and opcode-class
//            helpers shared by the control_unit_mb sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package cu_pkg;

    localparam logic [7:0] OP_LDA_IMM = 8'h86;
    localparam logic [7:0] OP_LDA_DIR = 8'h87;
    localparam logic [7:0] OP_LDB_IMM = 8'h88;
    localparam logic [7:0] OP_LDB_DIR = 8'h89;
    localparam logic [7:0] OP_STA_DIR = 8'h96;
    localparam logic [7:0] OP_STB_DIR = 8'h97;

    localparam logic [7:0] OP_ADD_AB  = 8'h42;
    localparam logic [7:0] OP_SUB_AB  = 8'h43;
    localparam logic [7:0] OP_AND_AB  = 8'h44;
    localparam logic [7:0] OP_OR_AB   = 8'h45;
    localparam logic [7:0] OP_INCA    = 8'h46;
    localparam logic [7:0] OP_INCB    = 8'h47;
    localparam logic [7:0] OP_DECA    = 8'h48;
    localparam logic [7:0] OP_DECB    = 8'h49;
    localparam logic [7:0] OP_XOR_AB  = 8'h4A;
    localparam logic [7:0] OP_NOTA    = 8'h4B;
    localparam logic [7:0] OP_NOTB    = 8'h4C;

    localparam logic [7:0] OP_BRA     = 8'h20;
    localparam logic [7:0] OP_BMI     = 8'h21;
    localparam logic [7:0] OP_BPL     = 8'h22;
    localparam logic [7:0] OP_BEQ     = 8'h23;
    localparam logic [7:0] OP_BNE     = 8'h24;
    localparam logic [7:0] OP_BVS     = 8'h25;
    localparam logic [7:0] OP_BVC     = 8'h26;
    localparam logic [7:0] OP_BCS     = 8'h27;
    localparam logic [7:0] OP_BCC     = 8'h28;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_INC = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_DEC = 3'b110;
    localparam logic [2:0] ALU_NOT = 3'b111;

    localparam logic [1:0] BUS1_PC = 2'b00;
    localparam logic [1:0] BUS1_A  = 2'b01;
    localparam logic [1:0] BUS1_B  = 2'b10;

    localparam logic [1:0] BUS2_ALU  = 2'b00;
    localparam logic [1:0] BUS2_BUS1 = 2'b01;
    localparam logic [1:0] BUS2_MEM  = 2'b10;
    localparam logic [1:0] BUS2_AR   = 2'b11;

    typedef enum logic [4:0] {
        S_FETCH0 = 5'd0,
        S_FETCH1 = 5'd1,
        S_FETCH2 = 5'd2,
        S_DECODE = 5'd3,
        S_IMM0   = 5'd4,
        S_IMM1   = 5'd5,
        S_IMM2   = 5'd6,
        S_OPND0  = 5'd7,
        S_OPND1  = 5'd8,
        S_OPND2  = 5'd9,
        S_LDD0   = 5'd10,
        S_LDD1   = 5'd11,
        S_LDD2   = 5'd12,
        S_STD0   = 5'd13,
        S_STD1   = 5'd14,
        S_ALU_EX = 5'd15,
        S_BR_LD  = 5'd16,
        S_SKIP   = 5'd17,
        S_TRAP   = 5'd18
    } state_t;

    function automatic logic is_ld_imm(input logic [7:0] op);
        return (op == OP_LDA_IMM) || (op == OP_LDB_IMM);
    endfunction

    function automatic logic is_ld_dir(input logic [7:0] op);
        return (op == OP_LDA_DIR) || (op == OP_LDB_DIR);
    endfunction

    function automatic logic is_st_dir(input logic [7:0] op);
        return (op == OP_STA_DIR) || (op == OP_STB_DIR);
    endfunction

    function automatic logic is_alu_op(input logic [7:0] op);
        return op inside {OP_ADD_AB, OP_SUB_AB, OP_AND_AB, OP_OR_AB, OP_INCA,
                          OP_INCB, OP_DECA, OP_DECB, OP_XOR_AB, OP_NOTA, OP_NOTB};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cu_branch_eval.sv
`default_nettype none
// ============================================================================
// Module   : cu_branch_eval
// Desc     : Combinational branch classifier: flags branch opcodes and
//            evaluates their condition against the N/Z/V/C flags.
// Revision : 1.0 - initial release
// ============================================================================
module cu_branch_eval
    import cu_pkg::*;
(
    input  logic [7:0] ir,
    input  logic [3:0] ccr,
    output logic       is_branch,
    output logic       taken
);

    always_comb begin
        is_branch = 1'b1;
        taken     = 1'b0;
        case (ir)
            OP_BRA:  taken = 1'b1;
            OP_BMI:  taken = ccr[3];
            OP_BPL:  taken = ~ccr[3];
            OP_BEQ:  taken = ccr[2];
            OP_BNE:  taken = ~ccr[2];
            OP_BVS:  taken = ccr[1];
            OP_BVC:  taken = ~ccr[1];
            OP_BCS:  taken = ccr[0];
            OP_BCC:  taken = ~ccr[0];
            default: is_branch = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_unit_mb.sv
`default_nettype none
// ============================================================================
// Module   : control_unit_mb
// Desc     : Moore fetch/decode/execute sequencer for the accumulator CPU with
//            multi-byte operand addresses. Option macro: CU_ILLEGAL_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module control_unit_mb
    import cu_pkg::*;
#(
    parameter int ADDR_BYTES = 2,
    parameter int CNT_W      = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [7:0]            IR,
    input  logic [3:0]            CCR_Result,
    output logic                  IR_Load,
    output logic                  MAR_Load,
    output logic [ADDR_BYTES-1:0] AR_Lane_Load,
    output logic                  PC_Load,
    output logic                  PC_Inc,
    output logic                  A_Load,
    output logic                  B_Load,
    output logic                  CCR_Load,
    output logic [2:0]            ALU_Sel,
    output logic [1:0]            Bus1_Sel,
    output logic [1:0]            Bus2_Sel,
    output logic                  write,
    output logic                  Illegal
);

    generate
        if (ADDR_BYTES < 1 || ADDR_BYTES > 4 || CNT_W < 1 || (2**CNT_W) < ADDR_BYTES) begin : g_param_error
            $error("control_unit_mb: ADDR_BYTES must be 1..4 and 2**CNT_W >= ADDR_BYTES");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADDR_BYTES - 1);
    // Lane 0 (MSB byte, fetched first) sits in the top bit of the one-hot vector.
    localparam logic [ADDR_BYTES-1:0] LANE_FIRST = ADDR_BYTES'(1) << (ADDR_BYTES - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             cnt_last;
    logic             is_branch;
    logic             br_taken;

    cu_branch_eval u_branch_eval (
        .ir        (IR),
        .ccr       (CCR_Result),
        .is_branch (is_branch),
        .taken     (br_taken)
    );

    assign cnt_last = (cnt == CNT_LAST);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= S_FETCH0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_FETCH0: state_next = S_FETCH1;
            S_FETCH1: state_next = S_FETCH2;
            S_FETCH2: state_next = S_DECODE;
            S_DECODE: begin
                if (is_ld_imm(IR))
                    state_next = S_IMM0;
                else if (is_ld_dir(IR) || is_st_dir(IR))
                    state_next = S_OPND0;
                else if (is_alu_op(IR))
                    state_next = S_ALU_EX;
                else if (is_branch)
                    state_next = br_taken ? S_OPND0 : S_SKIP;
                else
`ifdef CU_ILLEGAL_TRAP_EN
                    state_next = S_TRAP;
`else
                    state_next = S_FETCH0;
`endif
            end
            S_IMM0:   state_next = S_IMM1;
            S_IMM1:   state_next = S_IMM2;
            S_IMM2:   state_next = S_FETCH0;
            S_OPND0:  state_next = S_OPND1;
            S_OPND1:  state_next = S_OPND2;
            S_OPND2: begin
                if (cnt_last) begin
                    cnt_next = '0;
                    if (is_ld_dir(IR))
                        state_next = S_LDD0;
                    else if (is_st_dir(IR))
                        state_next = S_STD0;
                    else
                        state_next = S_BR_LD;
                end else begin
                    cnt_next   = cnt + CNT_W'(1);
                    state_next = S_OPND0;
                end
            end
            S_LDD0:   state_next = S_LDD1;
            S_LDD1:   state_next = S_LDD2;
            S_LDD2:   state_next = S_FETCH0;
            S_STD0:   state_next = S_STD1;
            S_STD1:   state_next = S_FETCH0;
            S_ALU_EX: state_next = S_FETCH0;
            S_BR_LD:  state_next = S_FETCH0;
            S_SKIP: begin
                if (cnt_last) begin
                    cnt_next   = '0;
                    state_next = S_FETCH0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_FETCH0;
        endcase
    end

    always_comb begin
        IR_Load      = 1'b0;
        MAR_Load     = 1'b0;
        AR_Lane_Load = '0;
        PC_Load      = 1'b0;
        PC_Inc       = 1'b0;
        A_Load       = 1'b0;
        B_Load       = 1'b0;
        CCR_Load     = 1'b0;
        ALU_Sel      = ALU_ADD;
        Bus1_Sel     = BUS1_PC;
        Bus2_Sel     = BUS2_ALU;
        write        = 1'b0;
        case (state)
            S_FETCH0, S_IMM0, S_OPND0: begin
                MAR_Load = 1'b1;
                Bus1_Sel = BUS1_PC;
                Bus2_Sel = BUS2_BUS1;
            end
            S_FETCH1, S_IMM1, S_OPND1, S_SKIP: PC_Inc = 1'b1;
            S_FETCH2: begin
                IR_Load  = 1'b1;
                Bus2_Sel = BUS2_MEM;
            end
            S_IMM2, S_LDD2: begin
                A_Load   = (IR == OP_LDA_IMM) || (IR == OP_LDA_DIR);
                B_Load   = (IR == OP_LDB_IMM) || (IR == OP_LDB_DIR);
                Bus2_Sel = BUS2_MEM;
                CCR_Load = 1'b1;
            end
            S_OPND2: begin
                AR_Lane_Load = LANE_FIRST >> cnt;
                Bus2_Sel     = BUS2_MEM;
            end
            S_LDD0, S_STD0: begin
                MAR_Load = 1'b1;
                Bus2_Sel = BUS2_AR;
            end
            S_STD1: begin
                write    = 1'b1;
                Bus1_Sel = (IR == OP_STA_DIR) ? BUS1_A : BUS1_B;
            end
            S_ALU_EX: begin
                CCR_Load = 1'b1;
                Bus2_Sel = BUS2_ALU;
                case (IR)
                    OP_ADD_AB: begin ALU_Sel = ALU_ADD; Bus1_Sel = BUS1_A; A_Load = 1'b1; end
                    OP_SUB_AB: begin ALU_Sel = ALU_SUB; Bus1_Sel = BUS1_A; A_Load = 1'b1; end
                    OP_AND_AB: begin ALU_Sel = ALU_AND; Bus1_Sel = BUS1_A; A_Load = 1'b1; end
                    OP_OR_AB:  begin ALU_Sel = ALU_OR;  Bus1_Sel = BUS1_A; A_Load = 1'b1; end
                    OP_XOR_AB: begin ALU_Sel = ALU_XOR; Bus1_Sel = BUS1_A; A_Load = 1'b1; end
                    OP_INCA:   begin ALU_Sel = ALU_INC; Bus1_Sel = BUS1_A; A_Load = 1'b1; end
                    OP_DECA:   begin ALU_Sel = ALU_DEC; Bus1_Sel = BUS1_A; A_Load = 1'b1; end
                    OP_NOTA:   begin ALU_Sel = ALU_NOT; Bus1_Sel = BUS1_A; A_Load = 1'b1; end
                    OP_INCB:   begin ALU_Sel = ALU_INC; Bus1_Sel = BUS1_B; B_Load = 1'b1; end
                    OP_DECB:   begin ALU_Sel = ALU_DEC; Bus1_Sel = BUS1_B; B_Load = 1'b1; end
                    OP_NOTB:   begin ALU_Sel = ALU_NOT; Bus1_Sel = BUS1_B; B_Load = 1'b1; end
                    default:   ALU_Sel = ALU_ADD;
                endcase
            end
            S_BR_LD: begin
                PC_Load  = 1'b1;
                Bus2_Sel = BUS2_AR;
            end
            default: ;
        endcase
    end

`ifdef CU_ILLEGAL_TRAP_EN
    assign Illegal = (state == S_TRAP);
`else
    assign Illegal = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/control_unit_mb.md
Name: control_unit_mb

Overview:
Parametrised successor of the 8-bit accumulator CPU control unit: a Moore FSM sequencing fetch, decode and execute for the same instruction set.
- Operand addresses are ADDR_BYTES wide, fetched a byte at a time into a staging register AR, then transferred to MAR or PC.
- Untaken branches skip the address operand.
- Sits between the datapath (IR, CCR, buses, MAR, AR, PC) and memory.

Parameters:
ADDR_BYTES, 2, number of address bytes per direct/branch operand (1..4)
CNT_W, 2, width of byte counter; must satisfy 2**CNT_W >= ADDR_BYTES

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  synchronous, active-low reset
IR  input  8  opcode from instruction register
CCR_Result  input  4  flags [3]=N [2]=Z [1]=V [0]=C
IR_Load  output  1  load IR from Bus2
MAR_Load  output  1  load MAR from Bus2
AR_Lane_Load  output  ADDR_BYTES  one-hot; load AR byte lane k from Bus2 (lane 0 = MSB byte, fetched first)
PC_Load  output  1  load PC from Bus2
PC_Inc  output  1  PC <= PC+1
A_Load, B_Load  output  1 each  load A or B from Bus2
CCR_Load  output  1  capture ALU/load flags
ALU_Sel  output  3  000 add, 001 inc, 010 sub, 011 and, 100 or, 101 xor, 110 dec, 111 not
Bus1_Sel  output  2  00 PC, 01 A, 10 B
Bus2_Sel  output  2  00 ALU, 01 Bus1, 10 memory, 11 AR
write  output  1  memory write strobe
Illegal  output  1  sticky illegal-opcode flag (only with CU_ILLEGAL_TRAP_EN; otherwise tied 0)

Behaviour:
- Single clock Clk. Reset is synchronous and active-low: on any rising edge with Reset=0, state <= FETCH0 and byte counter <= 0, including mid-instruction.
- Outputs are decoded combinationally from the state (and IR where noted). Every unlisted output is 0 in every state.
- Reset-state outputs (FETCH0): MAR_Load=1, Bus1_Sel=00, Bus2_Sel=01; all other outputs 0.
- Fetch sequence:
  - FETCH0: MAR<-PC.
  - FETCH1: PC_Inc (memory latency cycle).
  - FETCH2: IR_Load, Bus2=10.
  - DECODE: no strobes.
- Decode, IR evaluated in DECODE:
  - LDx_IMM -> IMM0.
  - LDx_DIR, STx_DIR -> OPND0.
  - ALU opcodes -> ALU_EX.
  - Branch taken -> OPND0.
  - Branch not taken -> SKIP.
  - Anything else -> FETCH0.
- Branch condition uses CCR_Result as sampled in DECODE:
  - BRA always taken.
  - BMI N; BPL !N; BEQ Z; BNE !Z; BVS V; BVC !V; BCS C; BCC !C.
- Immediate load:
  - IMM0: MAR<-PC.
  - IMM1: PC_Inc.
  - IMM2: A_Load or B_Load per IR, Bus2=10, CCR_Load. Then -> FETCH0.
- Operand fetch, repeated for cnt = 0..ADDR_BYTES-1:
  - OPND0: MAR<-PC.
  - OPND1: PC_Inc.
  - OPND2: AR_Lane_Load[cnt]=1, Bus2=10.
  - At OPND2, if cnt == ADDR_BYTES-1 then cnt <= 0 and exit; else cnt++ -> OPND0.
  - Exit by opcode: loads -> LDD0; stores -> STD0; branches -> BR_LD.
- Direct load:
  - LDD0: MAR_Load, Bus2=11.
  - LDD1: idle.
  - LDD2: A_Load or B_Load, Bus2=10, CCR_Load.
- Direct store:
  - STD0: MAR_Load, Bus2=11.
  - STD1: write=1, Bus1=01 (STA) or 10 (STB).
- ALU_EX: CCR_Load, Bus2=00, ALU_Sel and destination per opcode:
  - A-destination ops (ADD, SUB, AND, OR, XOR, INCA, DECA, NOTA): Bus1=01, A_Load.
  - INCB, DECB, NOTB: Bus1=10, B_Load.
- BR_LD: PC_Load, Bus2=11.
- SKIP: PC_Inc for ADDR_BYTES consecutive cycles, counted with cnt; cnt returns to 0 on exit.
- Latency from FETCH0 back to FETCH0 (cycles):
  - ALU: 5.
  - IMM: 7.
  - LDD: 7+3·ADDR_BYTES.
  - STD: 6+3·ADDR_BYTES.
  - Taken branch: 5+3·ADDR_BYTES.
  - Untaken branch: 4+ADDR_BYTES.
- The opcode must stay stable in IR throughout execute; IR_Load asserts only in FETCH2.
- Elaboration error if ADDR_BYTES is outside 1..4 or 2**CNT_W < ADDR_BYTES.

Optional Feature:
CU_ILLEGAL_TRAP_EN
- Defined: an unknown opcode in DECODE -> TRAP state. TRAP asserts no strobes and holds; Illegal=1 while in TRAP. Only Reset leaves TRAP.
- Undefined: an unknown opcode is a NOP (DECODE -> FETCH0); the Illegal port is driven 0.

Decomposition:
- Package cu_pkg: opcode constants, ALU_Sel codes, Bus1/Bus2 select codes, and the state enum (state width 5).
- One natural sub-module, cu_branch_eval: combinational IR + CCR_Result -> is_branch and taken.
- The byte counter stays in the top module.

Test Plan:
- ADDR_BYTES=2, Reset=0 for 2 cycles mid-STD1 -> next state FETCH0, write=0, MAR_Load=1, cnt=0.
- LDA_DIR (0x87) -> AR_Lane_Load sequence 10,01 in two OPND2 cycles; LDD2 A_Load=1 CCR_Load=1 Bus2=10; total 13 cycles.
- BEQ (0x23) with Z=0 -> SKIP, PC_Inc high exactly 2 cycles, no PC_Load, back in FETCH0 after 6 cycles.
- BNE (0x24) with Z=0 -> 3 operand passes? No: 2 passes, then BR_LD PC_Load=1 Bus2=11; total 11 cycles.
- DECB (0x49) -> ALU_EX: Bus1=10, ALU_Sel=110, B_Load=1, CCR_Load=1, A_Load=0.
- Opcode 0xFF: with CU_ILLEGAL_TRAP_EN -> Illegal=1 and held until Reset; without it -> FETCH0 after DECODE, Illegal=0.
